// File: rtl/spi_xfer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : spi_xfer_sequencer
//  Purpose  : Round-robin arbiter and byte-transfer sequencer sharing one
//             SPI_TOP master among NREQ requesters. For each grant it loads
//             CONFIG_REG/DATA_SHIFT_REG, strobes SEL_DATA then SEL_CMD, waits
//             for the RX interrupt (or a timeout), clears the interrupts and
//             returns the received byte with a one-cycle done pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_xfer_sequencer #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 4096,
  localparam int TW     = $clog2(TIMEOUT + 1),
  localparam int OW     = $clog2(NREQ)
) (
  input  logic                 PCLK,
  input  logic                 PRESET,
  input  logic [NREQ-1:0]      req,
  input  logic [16*NREQ-1:0]   cfg,
  input  logic [8*NREQ-1:0]    tx,
  output logic [NREQ-1:0]      done,
  output logic [7:0]           rx_data,
  output logic                 err,
  output logic                 busy,
  output logic [OW-1:0]        owner,
  output logic [15:0]          CONFIG_REG,
  output logic [7:0]           DATA_SHIFT_REG,
  output logic                 SEL_DATA,
  output logic                 SEL_CMD,
  output logic [1:0]           SPI_INT_CLR,
  input  logic [1:0]           SPI_INT,
  input  logic [7:0]           RX_REG
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_CLEAR = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [OW:0]   NREQ_W   = NREQ[OW:0];
  localparam logic [OW-1:0] LAST_IDX = OW'(NREQ - 1);
  localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 1);

  logic [2:0]      state_q, state_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [OW-1:0]   rr_q, rr_d;
  logic [15:0]     cfg_q, cfg_d;
  logic [7:0]      dsr_q, dsr_d;
  logic [7:0]      rx_q, rx_d;
  logic            err_q, err_d;
  logic [TW-1:0]   cnt_q, cnt_d;
  logic            sel_data_q, sel_data_d;
  logic            sel_cmd_q, sel_cmd_d;
  logic [1:0]      clr_q, clr_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            busy_q;

  // TX interrupt is only ever cleared, never observed.
  logic w_unused_tx_int;
  assign w_unused_tx_int = SPI_INT[0];

  // Requests rotated so that the rr pointer lands on bit 0, then the lowest
  // set bit is isolated; its position is the offset from the pointer.
  logic [NREQ-1:0] w_rot;
  logic [NREQ-1:0] w_first;
  logic [OW-1:0]   w_off;
  logic [OW:0]     w_sum;
  logic [OW-1:0]   w_grant;
  logic [OW-1:0]   w_rr_next;
  logic [15:0]     w_cfg_arr [NREQ];
  logic [7:0]      w_tx_arr  [NREQ];

  assign w_rot   = NREQ'({req, req} >> rr_q);
  assign w_first = w_rot & (~w_rot + NREQ'(1));

  for (genvar b = 0; b < OW; b++) begin : g_enc
    logic [NREQ-1:0] w_sel;
    for (genvar g = 0; g < NREQ; g++) begin : g_bit
      assign w_sel[g] = (((g >> b) & 1) != 0) ? w_first[g] : 1'b0;
    end
    assign w_off[b] = |w_sel;
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_req
    assign w_cfg_arr[g] = cfg[16*g +: 16];
    assign w_tx_arr[g]  = tx[8*g +: 8];
  end

  // Pointer plus offset, wrapped modulo NREQ (works for non-power-of-2 NREQ).
  assign w_sum     = {1'b0, rr_q} + {1'b0, w_off};
  assign w_grant   = (w_sum >= NREQ_W) ? OW'(w_sum - NREQ_W) : w_sum[OW-1:0];
  assign w_rr_next = (w_grant == LAST_IDX) ? '0 : w_grant + OW'(1);

  // Next-state logic; every strobe is computed one cycle ahead so that the
  // outputs themselves come straight from flops.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_d       = rr_q;
    cfg_d      = cfg_q;
    dsr_d      = dsr_q;
    rx_d       = rx_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    sel_data_d = 1'b0;
    sel_cmd_d  = 1'b0;
    clr_d      = 2'b00;
    done_d     = '0;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          state_d    = S_LOAD;
          owner_d    = w_grant;
          rr_d       = w_rr_next;
          // Force master mode (bit6) and full duplex (bit7 low).
          cfg_d      = {w_cfg_arr[w_grant][15:8], 1'b0, 1'b1,
                        w_cfg_arr[w_grant][5:0]};
          dsr_d      = w_tx_arr[w_grant];
          sel_data_d = 1'b1;
        end
      end
      S_LOAD: begin
        state_d   = S_START;
        sel_cmd_d = 1'b1;
      end
      S_START: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        // A completion seen on the expiry cycle still counts as success.
        if (SPI_INT[1]) begin
          state_d = S_CLEAR;
          rx_d    = RX_REG;
          err_d   = 1'b0;
          clr_d   = 2'b11;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_CLEAR;
          rx_d    = 8'h00;
          err_d   = 1'b1;
          clr_d   = 2'b11;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      S_CLEAR: begin
        state_d = S_DONE;
        done_d  = NREQ'(1) << owner_q;
      end
      S_DONE: begin
        state_d = S_IDLE;
        err_d   = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q    <= S_IDLE;
      owner_q    <= '0;
      rr_q       <= '0;
      cfg_q      <= 16'h0000;
      dsr_q      <= 8'h00;
      rx_q       <= 8'h00;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      sel_data_q <= 1'b0;
      sel_cmd_q  <= 1'b0;
      clr_q      <= 2'b00;
      done_q     <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_q       <= rr_d;
      cfg_q      <= cfg_d;
      dsr_q      <= dsr_d;
      rx_q       <= rx_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      sel_data_q <= sel_data_d;
      sel_cmd_q  <= sel_cmd_d;
      clr_q      <= clr_d;
      done_q     <= done_d;
      busy_q     <= (state_d != S_IDLE);
    end
  end

  assign done           = done_q;
  assign rx_data        = rx_q;
  assign err            = err_q;
  assign busy           = busy_q;
  assign owner          = owner_q;
  assign CONFIG_REG     = cfg_q;
  assign DATA_SHIFT_REG = dsr_q;
  assign SEL_DATA       = sel_data_q;
  assign SEL_CMD        = sel_cmd_q;
  assign SPI_INT_CLR    = clr_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_xfer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_xfer_sequencer
//  Purpose  : Self-checking bench for spi_xfer_sequencer (NREQ=2, TIMEOUT=16)
//             with an arbitration/transfer reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_xfer_sequencer;

  localparam int NREQ    = 2;
  localparam int TIMEOUT = 16;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic [1:0]  req;
  logic [31:0] cfg;
  logic [15:0] tx;
  logic [1:0]  done;
  logic [7:0]  rx_data;
  logic        err;
  logic        busy;
  logic [0:0]  owner;
  logic [15:0] CONFIG_REG;
  logic [7:0]  DATA_SHIFT_REG;
  logic        SEL_DATA;
  logic        SEL_CMD;
  logic [1:0]  SPI_INT_CLR;
  logic [1:0]  SPI_INT;
  logic [7:0]  RX_REG;

  int n_checks = 0;
  int n_fail   = 0;
  int m_rr     = 0;   // model round-robin pointer

  spi_xfer_sequencer #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .req(req), .cfg(cfg), .tx(tx),
    .done(done), .rx_data(rx_data), .err(err), .busy(busy), .owner(owner),
    .CONFIG_REG(CONFIG_REG), .DATA_SHIFT_REG(DATA_SHIFT_REG),
    .SEL_DATA(SEL_DATA), .SEL_CMD(SEL_CMD), .SPI_INT_CLR(SPI_INT_CLR),
    .SPI_INT(SPI_INT), .RX_REG(RX_REG)
  );

  always #5 PCLK = ~PCLK;

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  // First requester with req set, scanning from the pointer and wrapping.
  function automatic int model_grant(input logic [1:0] r, input int ptr);
    for (int k = 0; k < NREQ; k++)
      if (r[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  // One complete transfer started from an IDLE cycle, with a fixed expected
  // cycle schedule: LOAD, START, wait_len WAIT cycles, CLEAR, DONE, IDLE.
  task automatic run_xfer(input logic [1:0] r0, input logic [1:0] r_wait,
                          input bit resp, input int d, input logic [7:0] rxb);
    int g;
    int wait_len;
    bit ok;
    logic [15:0] ecfg;
    logic [7:0]  etx;
    logic [7:0]  erx;
    logic [1:0]  edone;
    req  = r0;
    g    = model_grant(r0, m_rr);
    ecfg = (cfg[16*g +: 16] | 16'h0040) & 16'hFF7F;
    etx  = tx[8*g +: 8];
    ok   = resp && (d <= TIMEOUT - 1);
    wait_len = ok ? d + 1 : TIMEOUT;
    erx   = ok ? rxb : 8'h00;
    edone = 2'b01 << g;
    m_rr  = (g + 1) % NREQ;

    tick();  // LOAD
    n_checks++;
    if ({SEL_DATA, SEL_CMD, busy, SPI_INT_CLR, done} !== 7'b1010000) begin
      n_fail++;
      $display("FAIL load_strobes: got %b expected %b",
               {SEL_DATA, SEL_CMD, busy, SPI_INT_CLR, done}, 7'b1010000);
    end
    n_checks++;
    if (owner !== 1'(g)) begin
      n_fail++; $display("FAIL grant_owner: got %0d expected %0d", owner, g);
    end
    n_checks++;
    if (CONFIG_REG !== ecfg) begin
      n_fail++; $display("FAIL config_reg: got %h expected %h", CONFIG_REG, ecfg);
    end
    n_checks++;
    if (DATA_SHIFT_REG !== etx) begin
      n_fail++; $display("FAIL data_shift_reg: got %h expected %h", DATA_SHIFT_REG, etx);
    end
    cfg = $urandom;   // changes after grant must not reach SPI_TOP
    tx  = 16'($urandom);

    tick();  // START
    n_checks++;
    if ({SEL_DATA, SEL_CMD, busy, SPI_INT_CLR, done} !== 7'b0110000) begin
      n_fail++;
      $display("FAIL start_strobes: got %b expected %b",
               {SEL_DATA, SEL_CMD, busy, SPI_INT_CLR, done}, 7'b0110000);
    end

    for (int j = 0; j < wait_len; j++) begin
      tick();  // WAIT cycle j
      n_checks++;
      if ({SEL_DATA, SEL_CMD, busy, SPI_INT_CLR, done} !== 7'b0010000) begin
        n_fail++;
        $display("FAIL wait_strobes[%0d]: got %b expected %b", j,
                 {SEL_DATA, SEL_CMD, busy, SPI_INT_CLR, done}, 7'b0010000);
      end
      req = r_wait;
      if (resp && j >= d) begin
        SPI_INT = {1'b1, 1'($urandom)};
        RX_REG  = rxb;
      end else begin
        SPI_INT = {1'b0, 1'($urandom)};
        RX_REG  = 8'($urandom);
      end
    end

    tick();  // CLEAR
    n_checks++;
    if ({SEL_DATA, SEL_CMD, busy, SPI_INT_CLR, done} !== 7'b0011100) begin
      n_fail++;
      $display("FAIL clear_strobes: got %b expected %b",
               {SEL_DATA, SEL_CMD, busy, SPI_INT_CLR, done}, 7'b0011100);
    end
    SPI_INT = 2'b00;
    RX_REG  = 8'($urandom);

    tick();  // DONE
    n_checks++;
    if ({SEL_DATA, SEL_CMD, busy, SPI_INT_CLR, done} !== {5'b00100, edone}) begin
      n_fail++;
      $display("FAIL done_pulse: got %b expected %b",
               {SEL_DATA, SEL_CMD, busy, SPI_INT_CLR, done}, {5'b00100, edone});
    end
    n_checks++;
    if (err !== !ok) begin
      n_fail++; $display("FAIL done_err: got %b expected %b", err, !ok);
    end
    n_checks++;
    if (rx_data !== erx) begin
      n_fail++; $display("FAIL done_rx_data: got %h expected %h", rx_data, erx);
    end
    n_checks++;
    if ({CONFIG_REG, DATA_SHIFT_REG} !== {ecfg, etx}) begin
      n_fail++;
      $display("FAIL held_regs: got %h expected %h", {CONFIG_REG, DATA_SHIFT_REG}, {ecfg, etx});
    end

    tick();  // IDLE
    n_checks++;
    if ({SEL_DATA, SEL_CMD, busy, SPI_INT_CLR, done, err} !== 8'b0) begin
      n_fail++;
      $display("FAIL idle_after_done: got %b expected %b",
               {SEL_DATA, SEL_CMD, busy, SPI_INT_CLR, done, err}, 8'b0);
    end
    n_checks++;
    if ({owner, CONFIG_REG} !== {1'(g), ecfg}) begin
      n_fail++;
      $display("FAIL idle_hold: got %h expected %h", {owner, CONFIG_REG}, {1'(g), ecfg});
    end
  endtask

  task automatic test_reset();
    PRESET = 1'b1; req = 2'b00; cfg = $urandom; tx = 16'($urandom);
    SPI_INT = 2'b00; RX_REG = 8'h00;
    tick(); tick();
    n_checks++;
    if ({SEL_DATA, SEL_CMD, busy, SPI_INT_CLR, done, err, owner} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected %b",
               {SEL_DATA, SEL_CMD, busy, SPI_INT_CLR, done, err, owner}, 9'b0);
    end
    n_checks++;
    if ({CONFIG_REG, DATA_SHIFT_REG, rx_data} !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h expected %h", {CONFIG_REG, DATA_SHIFT_REG, rx_data}, 32'h0);
    end
    PRESET = 1'b0;
    m_rr = 0;
    tick();
  endtask

  task automatic test_contention();
    for (int i = 0; i < 4; i++) begin
      cfg = $urandom; tx = 16'($urandom);
      run_xfer(2'b11, 2'b11, 1'b1, $urandom_range(0, 6), 8'($urandom));
    end
  endtask

  task automatic test_single();
    cfg = {16'($urandom), 16'h0000};
    tx  = {8'($urandom), 8'hA5};
    run_xfer(2'b01, 2'b01, 1'b1, 9, 8'h3C);
    req = 2'b00;
  endtask

  task automatic test_timeout();
    cfg = $urandom; tx = 16'($urandom);
    run_xfer(2'b01, 2'b01, 1'b0, 0, 8'hEE);
    req = 2'b00;
  endtask

  task automatic test_race();
    cfg = $urandom; tx = 16'($urandom);
    run_xfer(2'b10, 2'b10, 1'b1, TIMEOUT - 1, 8'h77);
    req = 2'b00;
  endtask

  task automatic test_req_withdrawn();
    cfg = $urandom; tx = 16'($urandom);
    run_xfer(2'b01, 2'b00, 1'b1, 4, 8'($urandom));
  endtask

  task automatic test_reset_mid_wait();
    bit seen_done;
    cfg = $urandom; tx = 16'($urandom);
    req = 2'b01;
    for (int i = 0; i < 5; i++) tick();   // LOAD, START, three WAIT cycles
    PRESET = 1'b1;
    req = 2'b00;
    tick();
    n_checks++;
    if ({busy, SEL_DATA, SEL_CMD, SPI_INT_CLR, done, owner, CONFIG_REG} !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_mid_wait: got %h expected %h",
               {busy, SEL_DATA, SEL_CMD, SPI_INT_CLR, done, owner, CONFIG_REG}, 24'h0);
    end
    PRESET = 1'b0;
    m_rr = 0;
    seen_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done !== 2'b00 || busy !== 1'b0) seen_done = 1'b1;
    end
    n_checks++;
    if (seen_done !== 1'b0) begin
      n_fail++; $display("FAIL no_done_after_reset: got %b expected %b", seen_done, 1'b0);
    end
    cfg = $urandom; tx = 16'($urandom);
    run_xfer(2'b10, 2'b10, 1'b1, $urandom_range(0, 5), 8'($urandom));
    req = 2'b00;
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      int idle;
      idle = $urandom_range(0, 2);
      req = 2'b00;
      for (int k = 0; k < idle; k++) begin
        tick();
        n_checks++;
        if ({busy, SEL_DATA} !== 2'b00) begin
          n_fail++; $display("FAIL idle_quiet: got %b expected %b", {busy, SEL_DATA}, 2'b00);
        end
      end
      cfg = $urandom; tx = 16'($urandom);
      run_xfer(2'($urandom_range(1, 3)), 2'($urandom_range(0, 3)),
               ($urandom_range(0, 3) != 0), $urandom_range(0, 20), 8'($urandom));
    end
    req = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_contention();
    test_single();
    test_timeout();
    test_race();
    test_req_withdrawn();
    test_reset_mid_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
